// File: rtl/dcache_miss_handler.sv
// Data-cache miss handler: writes back a dirty victim, fetches the missing block and repairs the cache.
// Optional performance counters are compiled in when DCACHE_MHU_PERF_EN is defined.
module dcache_miss_handler #(
  parameter  int BLOCK_OFFSET_BITS = 2,
  localparam int BLOCK_BITS        = 32 << BLOCK_OFFSET_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [31:0]           miss_addr_i,
  input  logic                  miss_store_i,
  input  logic                  victim_dirty_i,
  input  logic [31:0]           victim_addr_i,
  input  logic [BLOCK_BITS-1:0] victim_block_i,

  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_we_o,
  output logic [31:0]           mem_req_addr_o,
  output logic [BLOCK_BITS-1:0] mem_req_wdata_o,
  input  logic                  mem_resp_valid_i,
  input  logic [BLOCK_BITS-1:0] mem_resp_data_i,

  output logic                  repair_en_o,
  output logic [31:0]           repair_addr_o,
  output logic [BLOCK_BITS-1:0] repair_data_o,
  output logic                  repair_dirty_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef DCACHE_MHU_PERF_EN
  ,
  output logic [31:0]           perf_miss_cnt_o,
  output logic [31:0]           perf_wb_cnt_o,
  output logic [31:0]           perf_stall_cnt_o
`endif
);

  // Clears the byte and word offset bits so every address names a whole block.
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << (BLOCK_OFFSET_BITS + 2)) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_REPAIR
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           miss_addr_q;
  logic [31:0]           victim_addr_q;
  logic [BLOCK_BITS-1:0] victim_block_q;
  logic [BLOCK_BITS-1:0] fill_data_q;
  logic                  store_q;
  logic                  miss_accept;
  logic                  fill_capture;

  assign miss_accept  = (state_q == S_IDLE) && miss_valid_i;
  assign fill_capture = (state_q == S_FILL_WAIT) && mem_resp_valid_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the block registers are reset as well, so an aborted miss leaves no
  // stale victim or fill data behind to reach the memory or repair ports.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_addr_q    <= '0;
      victim_addr_q  <= '0;
      victim_block_q <= '0;
      store_q        <= 1'b0;
      fill_data_q    <= '0;
    end else begin
      if (miss_accept) begin
        miss_addr_q    <= miss_addr_i & ALIGN_MASK;
        victim_addr_q  <= victim_addr_i & ALIGN_MASK;
        victim_block_q <= victim_block_i;
        store_q        <= miss_store_i;
      end
      if (fill_capture) begin
        fill_data_q <= mem_resp_data_i;
      end
    end
  end

  // NOTE: every output and state_d gets a default before the case statement,
  // so no path through the block can leave a signal unassigned (no latches).
  always_comb begin
    state_d         = state_q;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    repair_en_o     = 1'b0;
    repair_addr_o   = '0;
    repair_data_o   = '0;
    repair_dirty_o  = 1'b0;
    done_o          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          state_d = victim_dirty_i ? S_WB_REQ : S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = victim_addr_q;
        mem_req_wdata_o = victim_block_q;
        if (mem_req_ready_i) begin
          state_d = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = miss_addr_q;
        if (mem_req_ready_i) begin
          state_d = S_FILL_WAIT;
        end
      end
      S_FILL_WAIT: begin
        if (mem_resp_valid_i) begin
          state_d = S_REPAIR;
        end
      end
      S_REPAIR: begin
        repair_en_o    = 1'b1;
        repair_addr_o  = miss_addr_q;
        repair_data_o  = fill_data_q;
        repair_dirty_o = store_q;
        done_o         = 1'b1;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

`ifdef DCACHE_MHU_PERF_EN
  logic wb_accept;

  assign wb_accept = (state_q == S_WB_REQ) && mem_req_ready_i;

  // Counters hold at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_miss_cnt_o  <= '0;
      perf_wb_cnt_o    <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (miss_accept && (perf_miss_cnt_o != 32'hFFFF_FFFF)) begin
        perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
      end
      if (wb_accept && (perf_wb_cnt_o != 32'hFFFF_FFFF)) begin
        perf_wb_cnt_o <= perf_wb_cnt_o + 32'd1;
      end
      if (busy_o && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Directed self-checking bench for dcache_miss_handler with a zero-wait memory responder.
// Counter checks are compiled in when DCACHE_MHU_PERF_EN is defined.
module tb_dcache_miss_handler;

  localparam int BB = 128;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          miss_valid_i;
  logic          miss_ready_o;
  logic [31:0]   miss_addr_i;
  logic          miss_store_i;
  logic          victim_dirty_i;
  logic [31:0]   victim_addr_i;
  logic [BB-1:0] victim_block_i;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic          mem_req_we_o;
  logic [31:0]   mem_req_addr_o;
  logic [BB-1:0] mem_req_wdata_o;
  logic          mem_resp_valid_i;
  logic [BB-1:0] mem_resp_data_i;
  logic          repair_en_o;
  logic [31:0]   repair_addr_o;
  logic [BB-1:0] repair_data_o;
  logic          repair_dirty_o;
  logic          busy_o;
  logic          done_o;
`ifdef DCACHE_MHU_PERF_EN
  logic [31:0]   perf_miss_cnt_o;
  logic [31:0]   perf_wb_cnt_o;
  logic [31:0]   perf_stall_cnt_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Results recorded by do_miss for the caller to compare.
  int            r_lat;
  int            r_nwr;
  int            r_nrd;
  logic          r_first_we;
  logic [31:0]   r_wr_addr;
  logic [BB-1:0] r_wr_data;
  logic [31:0]   r_rd_addr;
  logic [BB-1:0] r_rd_wdata;
  logic [31:0]   r_rep_addr;
  logic [BB-1:0] r_rep_data;
  logic          r_rep_dirty;

  localparam logic [BB-1:0] A5_BLOCK = {16{8'hA5}};
  localparam logic [BB-1:0] JUNK     = {4{32'hBAD0_BAD0}};

  dcache_miss_handler dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .miss_valid_i     (miss_valid_i),
    .miss_ready_o     (miss_ready_o),
    .miss_addr_i      (miss_addr_i),
    .miss_store_i     (miss_store_i),
    .victim_dirty_i   (victim_dirty_i),
    .victim_addr_i    (victim_addr_i),
    .victim_block_i   (victim_block_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_we_o     (mem_req_we_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_wdata_o  (mem_req_wdata_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .repair_en_o      (repair_en_o),
    .repair_addr_o    (repair_addr_o),
    .repair_data_o    (repair_data_o),
    .repair_dirty_o   (repair_dirty_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
`ifdef DCACHE_MHU_PERF_EN
    ,
    .perf_miss_cnt_o  (perf_miss_cnt_o),
    .perf_wb_cnt_o    (perf_wb_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Issues one miss, then plays a zero-wait memory: request ready is held low
  // for the first 'stall' busy cycles (optionally with junk responses), and a
  // fill response is returned the cycle after a read is accepted.
  task automatic do_miss(input logic [31:0] addr, input logic store, input logic vdirty,
                         input logic [31:0] vaddr, input logic [BB-1:0] vblock,
                         input logic [BB-1:0] fill, input int stall, input logic spur);
    logic          pend;
    logic          hold_we;
    logic [31:0]   hold_addr;
    logic [BB-1:0] hold_wdata;
    pend = 1'b0;
    hold_we = 1'b0;
    hold_addr = '0;
    hold_wdata = '0;
    r_lat = 0;
    r_nwr = 0;
    r_nrd = 0;
    r_first_we = 1'b0;
    check("accept_ready", miss_ready_o, 1);
    miss_valid_i   = 1'b1;
    miss_addr_i    = addr;
    miss_store_i   = store;
    victim_dirty_i = vdirty;
    victim_addr_i  = vaddr;
    victim_block_i = vblock;
    tick();
    // Scramble the request inputs so only the captured copies can be used.
    miss_valid_i   = 1'b0;
    miss_addr_i    = 32'hDEAD_BEEF;
    miss_store_i   = ~store;
    victim_dirty_i = ~vdirty;
    victim_addr_i  = 32'hFFFF_FFF0;
    victim_block_i = ~vblock;
    for (int c = 1; c <= 40; c++) begin
      mem_req_ready_i  = (c > stall);
      mem_resp_valid_i = pend | (spur && (c <= stall));
      mem_resp_data_i  = pend ? fill : JUNK;
      pend = 1'b0;
      check("busy_during_miss", busy_o, 1);
      check("not_ready_during_miss", miss_ready_o, 0);
      if (c == 1) begin
        hold_we    = mem_req_we_o;
        hold_addr  = mem_req_addr_o;
        hold_wdata = mem_req_wdata_o;
      end
      if (c <= stall) begin
        check("stall_valid", mem_req_valid_o, 1);
        check("stall_we", mem_req_we_o, hold_we);
        check("stall_addr", mem_req_addr_o, hold_addr);
        check("stall_wdata", mem_req_wdata_o, hold_wdata);
      end
      if (done_o) begin
        check("repair_with_done", repair_en_o, 1);
        r_lat       = c;
        r_rep_addr  = repair_addr_o;
        r_rep_data  = repair_data_o;
        r_rep_dirty = repair_dirty_o;
        break;
      end
      check("no_repair_early", repair_en_o, 0);
      if (mem_req_valid_o && mem_req_ready_i) begin
        if (r_nwr + r_nrd == 0) r_first_we = mem_req_we_o;
        if (mem_req_we_o) begin
          r_nwr++;
          r_wr_addr = mem_req_addr_o;
          r_wr_data = mem_req_wdata_o;
        end else begin
          r_nrd++;
          r_rd_addr  = mem_req_addr_o;
          r_rd_wdata = mem_req_wdata_o;
          pend = 1'b1;
        end
      end
      tick();
    end
    check("done_seen", (r_lat != 0), 1);
    mem_resp_valid_i = 1'b0;
    mem_req_ready_i  = 1'b1;
    tick();
    check("idle_after_repair", busy_o, 0);
    check("no_repair_after", repair_en_o, 0);
  endtask

  initial begin
    rst_ni           = 1'b0;
    miss_valid_i     = 1'b0;
    miss_addr_i      = '0;
    miss_store_i     = 1'b0;
    victim_dirty_i   = 1'b0;
    victim_addr_i    = '0;
    victim_block_i   = '0;
    mem_req_ready_i  = 1'b1;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;

    @(negedge clk_i);
    check("rst_miss_ready", miss_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_req_valid", mem_req_valid_o, 0);
    check("rst_req_addr", mem_req_addr_o, 0);
    check("rst_repair_en", repair_en_o, 0);
    check("rst_done", done_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Clean load miss.
    do_miss(32'h0000_1234, 1'b0, 1'b0, 32'h0000_7770, A5_BLOCK, 128'hCAFE_0001, 0, 1'b0);
    check("clean_latency", r_lat, 3);
    check("clean_nwr", r_nwr, 0);
    check("clean_nrd", r_nrd, 1);
    check("clean_rd_addr", r_rd_addr, 32'h0000_1230);
    check("clean_rd_wdata", r_rd_wdata, 0);
    check("clean_rep_addr", r_rep_addr, 32'h0000_1230);
    check("clean_rep_data", r_rep_data, 128'hCAFE_0001);
    check("clean_rep_dirty", r_rep_dirty, 0);

    // Dirty store miss.
    do_miss(32'h0000_2008, 1'b1, 1'b1, 32'h0000_4000, A5_BLOCK, 128'h1111_2222, 0, 1'b0);
    check("dirty_latency", r_lat, 4);
    check("dirty_first_we", r_first_we, 1);
    check("dirty_nwr", r_nwr, 1);
    check("dirty_wr_addr", r_wr_addr, 32'h0000_4000);
    check("dirty_wr_data", r_wr_data, A5_BLOCK);
    check("dirty_rd_addr", r_rd_addr, 32'h0000_2000);
    check("dirty_rep_addr", r_rep_addr, 32'h0000_2000);
    check("dirty_rep_dirty", r_rep_dirty, 1);
    check("dirty_rep_data", r_rep_data, 128'h1111_2222);

    // Backpressure in WB_REQ for 5 cycles.
    do_miss(32'h0000_5010, 1'b0, 1'b1, 32'h0000_6000, ~A5_BLOCK, 128'h3333, 5, 1'b0);
    check("bp_latency", r_lat, 9);
    check("bp_nwr", r_nwr, 1);
    check("bp_wr_addr", r_wr_addr, 32'h0000_6000);
    check("bp_wr_data", r_wr_data, ~A5_BLOCK);
    check("bp_rep_dirty", r_rep_dirty, 0);

    // Spurious responses in IDLE, then in FILL_REQ.
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = JUNK;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("spur_idle_busy", busy_o, 0);
      check("spur_idle_repair", repair_en_o, 0);
    end
    mem_resp_valid_i = 1'b0;
    do_miss(32'h0000_8004, 1'b0, 1'b0, 32'h0000_9000, A5_BLOCK, 128'h1, 2, 1'b1);
    check("spur_latency", r_lat, 5);
    check("spur_rep_data", r_rep_data, 128'h1);
    check("spur_rep_addr", r_rep_addr, 32'h0000_8000);

    // Reset asserted in FILL_WAIT.
    miss_valid_i   = 1'b1;
    miss_addr_i    = 32'h0000_3010;
    miss_store_i   = 1'b1;
    victim_dirty_i = 1'b0;
    tick();
    miss_valid_i = 1'b0;
    tick();
    check("fw_busy", busy_o, 1);
    check("fw_req_valid", mem_req_valid_o, 0);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_ready", miss_ready_o, 1);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_req_valid", mem_req_valid_o, 0);
    check("async_rst_repair", repair_en_o, 0);
    @(negedge clk_i);
    rst_ni           = 1'b1;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = JUNK;
    tick();
    check("late_resp_repair", repair_en_o, 0);
    check("late_resp_busy", busy_o, 0);
    mem_resp_valid_i = 1'b0;
    tick();
    check("late_resp_repair2", repair_en_o, 0);
    do_miss(32'h0000_A00C, 1'b0, 1'b0, 32'h0, A5_BLOCK, 128'h4444, 0, 1'b0);
    check("post_rst_latency", r_lat, 3);
    check("post_rst_rep_data", r_rep_data, 128'h4444);
    check("post_rst_rep_addr", r_rep_addr, 32'h0000_A000);

    // Victim block equals miss block: write-back and fill both happen.
    do_miss(32'h0000_C004, 1'b0, 1'b1, 32'h0000_C000, A5_BLOCK, 128'h5555, 0, 1'b0);
    check("same_nwr", r_nwr, 1);
    check("same_nrd", r_nrd, 1);
    check("same_latency", r_lat, 4);

`ifdef DCACHE_MHU_PERF_EN
    rst_ni = 1'b0;
    tick();
    check("perf_rst_miss", perf_miss_cnt_o, 0);
    check("perf_rst_stall", perf_stall_cnt_o, 0);
    rst_ni = 1'b1;
    tick();
    do_miss(32'h0000_1100, 1'b0, 1'b0, 32'h0, A5_BLOCK, 128'h6, 0, 1'b0);
    do_miss(32'h0000_2200, 1'b1, 1'b1, 32'h0000_3300, A5_BLOCK, 128'h7, 0, 1'b0);
    check("perf_miss_cnt", perf_miss_cnt_o, 2);
    check("perf_wb_cnt", perf_wb_cnt_o, 1);
    check("perf_stall_cnt", perf_stall_cnt_o, 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
